cfa_write_arbiter: RTL
======================

Name: cfa_write_arbiter

Overview:
- Sits between the CFA interpolation datapath and the single-port RGB frame memory.
- Accepts up to three channel writes per pixel (green/red/blue, common address) and buffers them in a small FIFO.
- Serialises them to the memory one channel per cycle, in fixed order G→R→B, whenever the memory owner grants the port.
- Provides backpressure, a sticky overflow flag and a drain indication that the pass sequencer uses before starting the next pass.

Parameters:
- addressBitWidth, 17, width of the frame-memory address.
- dataBitWidth, 12, width of one colour sample.
- fifoDepth, 4, number of pixel entries buffered; power of two, ≥2.
- fifoPtrWidth, 2, log2(fifoDepth).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_we  in  3  per-channel write request: bit0 green, bit1 red, bit2 blue. Same encoding as the datapath writeEnable.
- in_addr  in  addressBitWidth  pixel address shared by all channels.
- in_green  in  dataBitWidth  green sample.
- in_red  in  dataBitWidth  red sample.
- in_blue  in  dataBitWidth  blue sample.
- in_ready  out  1  FIFO not full; write accepted this cycle.
- mem_grant  in  1  memory port available to this block this cycle.
- mem_we  out  1  memory write strobe (registered).
- mem_sel  out  2  channel select: 2'b01 green, 2'b10 red, 2'b11 blue.
- mem_addr  out  addressBitWidth  write address (registered).
- mem_data  out  dataBitWidth  write data (registered).
- drained  out  1  FIFO empty and no write in flight.
- overflow  out  1  sticky: a request arrived while full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset: FIFO count=0, read/write pointers=0, pending mask=0.
  - Outputs after reset: mem_we=0, mem_sel=0, mem_addr=0, mem_data=0, overflow=0, in_ready=1, drained=1.
  - Reset mid-operation discards all buffered entries; no further mem_we.
- Push: on an edge with in_we≠0 and in_ready=1, store {in_addr, three samples, in_we} at the write pointer. Write pointer increments and wraps modulo fifoDepth.
- in_ready = (count ≠ fifoDepth). It is derived from registered count only; there is no same-cycle pop-frees-slot path.
- in_we=0: nothing stored; all-zero masks are never queued.
- Push while full: request dropped; overflow set at that edge.
- overflow: ovf_clr clears it. If a drop and ovf_clr coincide, set wins.
- Head processing: a working mask is loaded from the head entry.
  - On each edge where the FIFO is non-empty and mem_grant=1, issue the lowest set channel in order G, R, B.
  - Issue means: register mem_we=1, mem_sel code, mem_addr=head addr, mem_data=that sample. Then clear that bit of the working mask.
  - When the last bit is issued, pop: read pointer increments (wraps) and the working mask reloads from the next entry on the following edge.
  - mem_grant=0 or FIFO empty at an edge: mem_we=0 next cycle; the other mem_* outputs hold their values.
- Throughput: one channel write per granted cycle. A 3-channel pixel takes 3 granted cycles.
- Latency: an entry pushed at edge k gives earliest mem_we=1 in the cycle after edge k+1.
- Simultaneous push and pop: the count is unchanged; both pointers advance.
- drained = (count==0) && !mem_we. It is the level the sequencer waits on after frameDone.
- Count width is fifoPtrWidth+1 bits; it never exceeds fifoDepth and never underflows.

Decomposition:
- Shared package: channel codes green=2'b01, red=2'b10, blue=2'b11, and a 3-bit write-mask bit index per channel. These are shared with the CFA top.
- One natural sub-module: cfa_wr_fifo, a synchronous FIFO with push, pop, full/empty and count, parameterised by width and depth.
- The arbiter holds the working mask, channel priority encoder and output registers.

Test Plan:
1. Reset, then in_we=3'b111, addr=5, G=100, R=200, B=300, mem_grant held 1 → three consecutive mem_we cycles: (01,5,100), (10,5,200), (11,5,300). drained returns to 1 the cycle after the last write.
2. in_we=3'b001 with G=7 at addr 0..3 on consecutive edges, mem_grant=0 → in_ready falls after the 4th push. A 5th push sets overflow=1 and is dropped. Raising grant yields exactly 4 green writes, addr 0..3.
3. Pixel with in_we=3'b110, mem_grant toggling 1,0,1 → red write, one idle cycle (mem_we=0, mem_addr held), then blue write. No green write.
4. FIFO full while grant=1 and a push arrives in the same cycle the head's last channel pops → push refused (in_ready=0). overflow=1 and count stays fifoDepth-1 afterwards.
5. ovf_clr asserted on the same edge as a new drop → overflow stays 1. ovf_clr alone next edge → overflow=0.
6. Reset asserted while two entries are queued and mem_we=1 → next cycle mem_we=0, in_ready=1, drained=1. No stale writes after reset deasserts.

Source files
------------

// File: rtl/cfa_write_arbiter_pkg.sv
// Shared definitions for the CFA frame-memory write path.
//   - chan_sel_e  : memory channel-select codes (green/red/blue), also used by the CFA top
//   - WE_BIT_*    : bit position of each channel inside the 3-bit write mask
//   - first_channel() : fixed G->R->B priority pick from a write mask
package cfa_write_arbiter_pkg;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'b00,
    SEL_GREEN = 2'b01,
    SEL_RED   = 2'b10,
    SEL_BLUE  = 2'b11
  } chan_sel_e;

  localparam int WE_BIT_GREEN = 0;
  localparam int WE_BIT_RED   = 1;
  localparam int WE_BIT_BLUE  = 2;
  localparam int NUM_CHANNELS = 3;

  // Lowest set channel wins; an empty mask yields SEL_IDLE.
  function automatic chan_sel_e first_channel(input logic [NUM_CHANNELS-1:0] mask);
    chan_sel_e sel;
    sel = SEL_IDLE;
    if (mask[WE_BIT_GREEN])     sel = SEL_GREEN;
    else if (mask[WE_BIT_RED])  sel = SEL_RED;
    else if (mask[WE_BIT_BLUE]) sel = SEL_BLUE;
    return sel;
  endfunction

endpackage

// File: rtl/cfa_wr_fifo.sv
// Small synchronous FIFO holding pixel write entries.
//   clk, rst      : clock, synchronous active-high reset
//   i_push/i_din  : write request and data (ignored while full)
//   i_pop         : release head entry (ignored while empty)
//   o_dout        : head entry, visible in the same cycle it is written behind
//   o_full/o_empty/o_count : occupancy, all from registered state
module cfa_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head read is combinational so a fresh entry can issue on the very next edge.
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/cfa_write_arbiter.sv
// Buffers per-pixel G/R/B writes from the CFA datapath and serialises them
// onto the single-port frame memory, one channel per granted cycle, G->R->B.
//   in_we/in_addr/in_green/in_red/in_blue : pixel write request (mask + data)
//   in_ready  : FIFO not full (request accepted this cycle)
//   mem_grant : memory port owned by this block this cycle
//   mem_we/mem_sel/mem_addr/mem_data : registered memory write port
//   drained   : nothing buffered and no write in flight
//   overflow/ovf_clr : sticky dropped-request flag and its clear
module cfa_write_arbiter
  import cfa_write_arbiter_pkg::*;
#(
  parameter int addressBitWidth = 17,
  parameter int dataBitWidth    = 12,
  parameter int fifoDepth       = 4,
  parameter int fifoPtrWidth    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 in_we,
  input  logic [addressBitWidth-1:0] in_addr,
  input  logic [dataBitWidth-1:0]    in_green,
  input  logic [dataBitWidth-1:0]    in_red,
  input  logic [dataBitWidth-1:0]    in_blue,
  output logic                       in_ready,
  input  logic                       mem_grant,
  output logic                       mem_we,
  output logic [1:0]                 mem_sel,
  output logic [addressBitWidth-1:0] mem_addr,
  output logic [dataBitWidth-1:0]    mem_data,
  output logic                       drained,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  // Entry layout, LSB first: write mask, green, red, blue, address.
  localparam int ENTRY_W = NUM_CHANNELS + 3 * dataBitWidth + addressBitWidth;
  localparam int OFS_G   = NUM_CHANNELS;
  localparam int OFS_R   = OFS_G + dataBitWidth;
  localparam int OFS_B   = OFS_R + dataBitWidth;
  localparam int OFS_A   = OFS_B + dataBitWidth;

  logic [ENTRY_W-1:0]         w_head;
  logic                       w_full;
  logic                       w_empty;
  logic [fifoPtrWidth:0]      w_count;
  logic                       w_push_req;
  logic                       w_drop;
  logic                       w_issue;
  logic                       w_pop;
  logic [NUM_CHANNELS-1:0]    w_work;
  logic [NUM_CHANNELS-1:0]    w_bit;
  logic [NUM_CHANNELS-1:0]    w_remaining;
  chan_sel_e                  w_sel;
  logic [dataBitWidth-1:0]    w_data;

  logic [NUM_CHANNELS-1:0]    r_done;
  logic                       r_mem_we;
  logic [1:0]                 r_mem_sel;
  logic [addressBitWidth-1:0] r_mem_addr;
  logic [dataBitWidth-1:0]    r_mem_data;
  logic                       r_overflow;

  assign w_push_req = |in_we;
  assign w_drop     = w_push_req & w_full;

  cfa_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (fifoDepth),
    .PTR_W (fifoPtrWidth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_din   ({in_addr, in_blue, in_red, in_green, in_we}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Working mask = head mask minus channels already issued for this pixel.
  // Tracking the issued bits (cleared on pop) makes the next head's mask
  // take effect automatically on the edge after the pop.
  assign w_work  = w_head[NUM_CHANNELS-1:0] & ~r_done;
  assign w_issue = ~w_empty & mem_grant;

  always_comb begin
    w_sel  = first_channel(w_work);
    w_bit  = '0;
    w_data = '0;
    case (w_sel)
      SEL_GREEN: begin
        w_bit[WE_BIT_GREEN] = 1'b1;
        w_data              = w_head[OFS_G +: dataBitWidth];
      end
      SEL_RED: begin
        w_bit[WE_BIT_RED] = 1'b1;
        w_data            = w_head[OFS_R +: dataBitWidth];
      end
      SEL_BLUE: begin
        w_bit[WE_BIT_BLUE] = 1'b1;
        w_data             = w_head[OFS_B +: dataBitWidth];
      end
      default: begin
        w_bit  = '0;
        w_data = '0;
      end
    endcase
  end

  assign w_remaining = w_work & ~w_bit;
  assign w_pop       = w_issue & (w_remaining == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done     <= '0;
      r_mem_we   <= 1'b0;
      r_mem_sel  <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_mem_we <= w_issue;
      if (w_issue) begin
        r_mem_sel  <= w_sel;
        r_mem_addr <= w_head[OFS_A +: addressBitWidth];
        r_mem_data <= w_data;
        r_done     <= w_pop ? '0 : (r_done | w_bit);
      end
      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign in_ready = ~w_full;
  assign mem_we   = r_mem_we;
  assign mem_sel  = r_mem_sel;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign overflow = r_overflow;
  assign drained  = (w_count == '0) & ~r_mem_we;

endmodule
